// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX
  } div_state_e;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_LATENCY = DIV_DATA_W + 2;
  // Sliced down to DATA_W at the point of use.
  localparam logic [127:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_iter_core_if.sv
// rtl/div_iter_core_if.sv - operand and result stream bundle for div_iter_core
interface div_iter_core_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   s_axis_dividend_tdata;
  logic                s_axis_dividend_tvalid;
  logic                s_axis_dividend_tready;
  logic [DATA_W-1:0]   s_axis_divisor_tdata;
  logic                s_axis_divisor_tvalid;
  logic                s_axis_divisor_tready;
  logic [2*DATA_W-1:0] m_axis_dout_tdata;
  logic                m_axis_dout_tuser;
  logic                m_axis_dout_tvalid;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid
  );
endinterface

// File: rtl/div_operand_slot.sv
// rtl/div_operand_slot.sv - one-entry operand slot with flush
// An operand arriving on the edge it is consumed bypasses the holding register.
module div_operand_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tvalid,
  output logic              tready,
  input  logic              take,
  output logic              avail,
  output logic [DATA_W-1:0] data
);
  logic              full;
  logic [DATA_W-1:0] held;

  assign tready = ~full & ~flush;
  assign avail  = full | (tvalid & tready);
  assign data   = full ? held : tdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      held <= '0;
    end else if (flush || take) begin
      full <= 1'b0;
    end else if (tvalid && tready) begin
      full <= 1'b1;
      held <= tdata;
    end
  end
endmodule

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - iterative radix-2 restoring divider, DATA_W+2 cycle latency
// Works on magnitudes; signs and the divide-by-zero result are applied in DIV_FIX.
module div_iter_core
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1,
  parameter int DATA_W = 32
) (
  input logic aclk,
  input logic aresetn,
  input logic flush,
  div_iter_core_if.slave axis
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  div_state_e        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic              neg_q, neg_r, zero_q;

  logic              dvd_avail, dvs_avail, take;
  logic [DATA_W-1:0] dvd_op, dvs_op;
  logic [DATA_W:0]   r_sh, diff;
  logic [DATA_W-1:0] q_fix, r_fix;

  function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
    return (SIGNED && v[DATA_W-1]) ? -v : v;
  endfunction

  div_operand_slot #(.DATA_W(DATA_W)) u_dvd_slot (
    .clk(aclk), .rst_n(aresetn), .flush(flush),
    .tdata(axis.s_axis_dividend_tdata), .tvalid(axis.s_axis_dividend_tvalid),
    .tready(axis.s_axis_dividend_tready), .take(take), .avail(dvd_avail), .data(dvd_op)
  );

  div_operand_slot #(.DATA_W(DATA_W)) u_dvs_slot (
    .clk(aclk), .rst_n(aresetn), .flush(flush),
    .tdata(axis.s_axis_divisor_tdata), .tvalid(axis.s_axis_divisor_tvalid),
    .tready(axis.s_axis_divisor_tready), .take(take), .avail(dvs_avail), .data(dvs_op)
  );

  // FIX doubles as a load slot so a prefetched pair starts with no bubble.
  assign take = ~flush & dvd_avail & dvs_avail & ((state == DIV_IDLE) | (state == DIV_FIX));

  assign r_sh  = {rem_q, quo_q[DATA_W-1]};
  assign diff  = r_sh - {1'b0, dvs_q};
  assign q_fix = zero_q ? DIV0_QUOTIENT[DATA_W-1:0] : (neg_q ? -quo_q : quo_q);
  assign r_fix = zero_q ? dvd_q : (neg_r ? -rem_q : rem_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                   <= DIV_IDLE;
      cnt                     <= '0;
      rem_q                   <= '0;
      quo_q                   <= '0;
      dvs_q                   <= '0;
      dvd_q                   <= '0;
      neg_q                   <= 1'b0;
      neg_r                   <= 1'b0;
      zero_q                  <= 1'b0;
      axis.m_axis_dout_tdata  <= '0;
      axis.m_axis_dout_tuser  <= 1'b0;
      axis.m_axis_dout_tvalid <= 1'b0;
    end else begin
      axis.m_axis_dout_tvalid <= 1'b0;
      if (flush) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_CALC: begin
            if (!diff[DATA_W]) begin
              rem_q <= diff[DATA_W-1:0];
              quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
              rem_q <= r_sh[DATA_W-1:0];
              quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DIV_FIX;
          end
          DIV_FIX: begin
            axis.m_axis_dout_tdata  <= {q_fix, r_fix};
            axis.m_axis_dout_tuser  <= zero_q;
            axis.m_axis_dout_tvalid <= 1'b1;
            state                   <= DIV_IDLE;
          end
          default: ;
        endcase
        if (take) begin
          state  <= DIV_CALC;
          cnt    <= '0;
          rem_q  <= '0;
          quo_q  <= mag_of(dvd_op);
          dvs_q  <= mag_of(dvs_op);
          dvd_q  <= dvd_op;
          neg_q  <= SIGNED && (dvd_op[DATA_W-1] ^ dvs_op[DATA_W-1]);
          neg_r  <= SIGNED && dvd_op[DATA_W-1];
          zero_q <= (dvs_op == '0);
        end
      end
    end
  end
endmodule
